// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider with glitch-free reconfiguration.
// Divide-factor and run/stop commands arrive over a valid/ready handshake and
// take effect only at a falling boundary of clk_out, so no phase is ever cut short.
//
// Ports:
//   clk_in     - the only clock
//   reset_n    - asynchronous active-low reset
//   cfg_valid  - command valid
//   cfg_ready  - command ready (high in IDLE and RUN)
//   cfg_div    - requested half-period in clk_in cycles (must be >= 2)
//   cfg_en     - 1 = run, 0 = stop
//   clk_out    - divided clock, period 2*div, 50% duty
//   tick       - one-cycle pulse coincident with each clk_out rising edge
//   running    - controller is not idle
//   cfg_err    - one-cycle pulse after a rejected command
module clk_div_ctrl #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  input  logic                 cfg_en,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 running,
  output logic                 cfg_err
);

  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] DIV_MIN = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] act_div, act_div_nxt;
  logic [CNT_WIDTH-1:0] pend_div, pend_div_nxt;
  logic                 clk_out_nxt;
  logic                 tick_nxt;
  logic                 cfg_err_nxt;
  logic                 xfer;
  logic                 bad_div;
  logic                 wrap;

  assign xfer    = cfg_valid && cfg_ready;
  assign bad_div = cfg_div < DIV_MIN;
  // act_div only changes when cnt is 0, so cnt never exceeds act_div-1
  assign wrap    = (cnt == (act_div - ONE));

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    act_div_nxt  = act_div;
    pend_div_nxt = pend_div;
    clk_out_nxt  = clk_out;
    tick_nxt     = 1'b0;
    cfg_err_nxt  = xfer && bad_div;

    if (state == S_IDLE) begin
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      if (xfer && !bad_div) begin
        act_div_nxt = cfg_div;
        if (cfg_en) begin
          state_nxt = S_RUN;
        end
      end
    end else begin
      if (wrap) begin
        cnt_nxt     = '0;
        clk_out_nxt = !clk_out;
        if (!clk_out) begin
          tick_nxt = 1'b1;
        end else begin
          // Falling boundary: the only point where queued commands apply
          case (state)
            S_PEND: begin
              act_div_nxt = pend_div;
              state_nxt   = S_RUN;
            end
            S_STOP: begin
              clk_out_nxt = 1'b0;
              state_nxt   = S_IDLE;
            end
            default: ;
          endcase
        end
      end else begin
        cnt_nxt = cnt + ONE;
      end

      // A command accepted in RUN is queued even on a boundary edge
      if (state == S_RUN && xfer && !bad_div) begin
        if (cfg_en) begin
          pend_div_nxt = cfg_div;
          state_nxt    = S_PEND;
        end else begin
          state_nxt = S_STOP;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      act_div   <= DIV_RST;
      pend_div  <= DIV_RST;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      cfg_err   <= 1'b0;
      running   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      act_div   <= act_div_nxt;
      pend_div  <= pend_div_nxt;
      clk_out   <= clk_out_nxt;
      tick      <= tick_nxt;
      cfg_err   <= cfg_err_nxt;
      running   <= (state_nxt != S_IDLE);
      cfg_ready <= (state_nxt == S_IDLE) || (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed commands, a phase-level reference model
// compared on every falling clk_in edge, and hand-computed literal checkpoints.
module tb_clk_div_ctrl;

  localparam int unsigned CW = 4;

  logic          clk_in;
  logic          reset_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_div;
  logic          cfg_en;
  logic          clk_out;
  logic          tick;
  logic          running;
  logic          cfg_err;

  int checks   = 0;
  int failures = 0;

  clk_div_ctrl #(.CNT_WIDTH(CW), .DEFAULT_DIV(2)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cfg_err   (cfg_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: phases of a given length, plus at most one queued command
  bit m_idle  = 1'b1;
  bit m_level = 1'b0;
  bit m_tick  = 1'b0;
  bit m_err   = 1'b0;
  int m_left  = 0;
  int m_div   = 2;
  int m_q     = 0;   // 0 none, 1 new div, 2 stop
  int m_qdiv  = 2;
  bit m_rdy, m_xfer, m_ok;

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      m_idle = 1'b1; m_level = 1'b0; m_tick = 1'b0; m_err = 1'b0;
      m_left = 0; m_div = 2; m_q = 0; m_qdiv = 2;
    end else begin
      m_rdy  = m_idle || (m_q == 0);
      m_xfer = cfg_valid && m_rdy;
      m_ok   = m_xfer && (int'(cfg_div) >= 2);
      m_err  = m_xfer && !m_ok;
      m_tick = 1'b0;
      if (m_idle) begin
        if (m_ok) begin
          m_div = int'(cfg_div);
          if (cfg_en) begin
            m_idle = 1'b0; m_level = 1'b0; m_left = m_div;
          end
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_level = !m_level;
          if (m_level) m_tick = 1'b1;
          else if (m_q == 1) begin m_div = m_qdiv; m_q = 0; end
          else if (m_q == 2) begin m_idle = 1'b1; m_q = 0; end
          m_left = m_div;
        end
        if (m_ok) begin
          if (cfg_en) begin m_q = 1; m_qdiv = int'(cfg_div); end
          else m_q = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model vs DUT on every cycle outside reset
  always @(negedge clk_in) begin
    if (reset_n) begin
      chk("m_clk_out", clk_out, m_level);
      chk("m_tick", tick, m_tick);
      chk("m_running", running, !m_idle);
      chk("m_cfg_ready", cfg_ready, m_idle || (m_q == 0));
      chk("m_cfg_err", cfg_err, m_err);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cfg_valid = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  // Issue a run command from IDLE; returns just after the accepting edge E0
  task automatic start(input int div);
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = CW'(div);
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic send(input int div, input bit en);
    cfg_valid = 1'b1; cfg_en = en; cfg_div = CW'(div);
  endtask

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_en = 1'b0; cfg_div = '0;
    step(2);
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    reset_n = 1'b1;
    step(1);

    // div=3 start: rise after E3, fall after E6, rise after E9
    start(3);
    chk("t1_running", running, 1'b1);
    chk("t1_clk_e0", clk_out, 1'b0);
    step(2); chk("t1_clk_e2", clk_out, 1'b0);
    step(1); chk("t1_clk_e3", clk_out, 1'b1); chk("t1_tick_e3", tick, 1'b1);
    step(1); chk("t1_tick_e4", tick, 1'b0);
    step(2); chk("t1_clk_e6", clk_out, 1'b0);
    step(3); chk("t1_clk_e9", clk_out, 1'b1); chk("t1_tick_e9", tick, 1'b1);

    // div 3 -> 5 during high phase
    send(5, 1'b1);
    step(1); cfg_valid = 1'b0; chk("t2_ready_acc", cfg_ready, 1'b0);
    step(1); chk("t2_clk_e11", clk_out, 1'b1); chk("t2_ready_e11", cfg_ready, 1'b0);
    step(1); chk("t2_clk_e12", clk_out, 1'b0); chk("t2_ready_e12", cfg_ready, 1'b1);
    step(4); chk("t2_clk_e16", clk_out, 1'b0);
    step(1); chk("t2_clk_e17", clk_out, 1'b1); chk("t2_tick_e17", tick, 1'b1);
    step(4); chk("t2_clk_e21", clk_out, 1'b1);
    step(1); chk("t2_clk_e22", clk_out, 1'b0);

    // Stop at div=4 sent in low phase
    do_reset();
    start(4);
    step(4); chk("t3_clk_e4", clk_out, 1'b1);
    step(4); chk("t3_clk_e8", clk_out, 1'b0);
    send(4, 1'b0);
    step(1); cfg_valid = 1'b0;
    chk("t3_ready_acc", cfg_ready, 1'b0); chk("t3_run_acc", running, 1'b1);
    step(3); chk("t3_clk_e12", clk_out, 1'b1); chk("t3_tick_e12", tick, 1'b1);
    step(3); chk("t3_clk_e15", clk_out, 1'b1); chk("t3_run_e15", running, 1'b1);
    step(1); chk("t3_clk_e16", clk_out, 1'b0); chk("t3_run_e16", running, 1'b0);
    chk("t3_ready_e16", cfg_ready, 1'b1);
    step(8); chk("t3_clk_idle", clk_out, 1'b0); chk("t3_tick_idle", tick, 1'b0);

    // Rejected divs while running at div=2
    do_reset();
    start(2);
    step(2); chk("t4_clk_e2", clk_out, 1'b1);
    step(2); chk("t4_clk_e4", clk_out, 1'b0);
    send(1, 1'b1);
    step(1); cfg_valid = 1'b0;
    chk("t4_err1", cfg_err, 1'b1); chk("t4_ready1", cfg_ready, 1'b1);
    chk("t4_run1", running, 1'b1);
    step(1); chk("t4_err1_end", cfg_err, 1'b0); chk("t4_clk_e6", clk_out, 1'b1);
    send(0, 1'b1);
    step(1); cfg_valid = 1'b0; chk("t4_err0", cfg_err, 1'b1);
    step(1); chk("t4_clk_e8", clk_out, 1'b0); chk("t4_err0_end", cfg_err, 1'b0);
    step(2); chk("t4_clk_e10", clk_out, 1'b1);

    // Asynchronous reset while in PEND
    do_reset();
    start(2);
    send(3, 1'b1);
    step(1); cfg_valid = 1'b0; chk("t5_ready_pend", cfg_ready, 1'b0);
    step(1); chk("t5_clk_e2", clk_out, 1'b1); chk("t5_tick_e2", tick, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_clk", clk_out, 1'b0); chk("t5_rst_tick", tick, 1'b0);
    chk("t5_rst_run", running, 1'b0); chk("t5_rst_ready", cfg_ready, 1'b1);
    step(1); reset_n = 1'b1;
    start(2);
    step(2); chk("t5_clk_e2b", clk_out, 1'b1);
    step(2); chk("t5_clk_e4b", clk_out, 1'b0);
    step(2); chk("t5_clk_e6b", clk_out, 1'b1);

    // Held command while PEND (2 -> 3 queued, then 6)
    do_reset();
    start(2);
    send(3, 1'b1);
    step(1); cfg_div = CW'(6);
    step(2); chk("t6_ready_e3", cfg_ready, 1'b0);
    step(1); chk("t6_ready_e4", cfg_ready, 1'b1); chk("t6_clk_e4", clk_out, 1'b0);
    step(1); cfg_valid = 1'b0; chk("t6_ready_e5", cfg_ready, 1'b0);
    step(1); chk("t6_clk_e6", clk_out, 1'b0);
    step(1); chk("t6_clk_e7", clk_out, 1'b1); chk("t6_tick_e7", tick, 1'b1);
    step(2); chk("t6_clk_e9", clk_out, 1'b1);
    step(1); chk("t6_clk_e10", clk_out, 1'b0); chk("t6_ready_e10", cfg_ready, 1'b1);
    step(5); chk("t6_clk_e15", clk_out, 1'b0);
    step(1); chk("t6_clk_e16", clk_out, 1'b1);
    step(6); chk("t6_clk_e22", clk_out, 1'b0);

    // Largest divide factor for a 4-bit counter
    do_reset();
    start(15);
    step(14); chk("t7_clk_e14", clk_out, 1'b0);
    step(1);  chk("t7_clk_e15", clk_out, 1'b1); chk("t7_tick_e15", tick, 1'b1);
    step(15); chk("t7_clk_e30", clk_out, 1'b0);
    step(15); chk("t7_clk_e45", clk_out, 1'b1);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock-divider controller. It generates a divided clock `clk_out` plus a one-cycle `tick` enable from `clk_in`. It accepts divide-factor and enable commands over a valid/ready handshake and applies every change only at a falling boundary of `clk_out`, so the output never shows a runt or truncated phase. It sits between the configuration/CSR logic and the clock-enable consumers in the design.

## Interface
- `CNT_WIDTH`, 16, width of the divide factor and the internal counter.
- `DEFAULT_DIV`, 2, active divide factor after reset; must be ≥2 and ≤2^CNT_WIDTH−1.

Ports:
- `clk_in`  in  1  the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  command valid.
- `cfg_ready`  out  1  command ready.
- `cfg_div`  in  CNT_WIDTH  requested half-period, in `clk_in` cycles.
- `cfg_en`  in  1  1 = run, 0 = stop.
- `clk_out`  out  1  divided clock; period is 2×div cycles, 50% duty.
- `tick`  out  1  one-cycle pulse, coincident with each rising edge of `clk_out`.
- `running`  out  1  controller is not in IDLE.
- `cfg_err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- Registers: `state`, `cnt`, `act_div`, `pend_div`. `cfg_ready`, `running` and `tick` are registered or decoded from registered state only.
- States:
  - IDLE: `clk_out`=0, `cnt`=0.
  - RUN: dividing.
  - PEND: dividing; a new divide factor is queued.
  - STOP: dividing; a stop is queued.
- `cfg_ready` = 1 in IDLE and RUN, 0 in PEND and STOP. A transfer occurs on an edge with `cfg_valid`=1 and `cfg_ready`=1.
- Reject rule: a transfer with `cfg_div` < 2 is dropped. `cfg_err`=1 for the following cycle. State, `act_div` and `clk_out` are unchanged.
- Transfers in IDLE:
  - `cfg_en`=1: `act_div`←`cfg_div`, `cnt`←0, go to RUN.
  - `cfg_en`=0: `act_div`←`cfg_div`, stay in IDLE.
- Transfers in RUN:
  - `cfg_en`=1: `pend_div`←`cfg_div`, go to PEND.
  - `cfg_en`=0: go to STOP. `cfg_div` is ignored.
- Counting (RUN, PEND, STOP):
  - If `cnt`==`act_div`−1: `cnt`←0 and `clk_out` toggles.
  - Otherwise `cnt`←`cnt`+1.
- Falling boundary = the edge where `clk_out` toggles 1→0.
  - PEND: `act_div`←`pend_div`, go to RUN.
  - STOP: `clk_out`←0, go to IDLE.
- Rising toggles (0→1) never change state.
- Simultaneous events:
  - A transfer in RUN on the same edge as a falling boundary goes to PEND/STOP. It is applied at the *next* falling boundary, not at this one.
- `running` = 1 in RUN, PEND and STOP.

## Timing
- Reset (asynchronous, immediate on `reset_n`=0):
  - state = IDLE, `cnt`=0, `act_div`=`pend_div`=DEFAULT_DIV.
  - `clk_out`=0, `tick`=0, `cfg_err`=0, `running`=0, `cfg_ready`=1.
- Reset mid-operation discards any queued command. `clk_out` drops to 0 asynchronously.
- Start latency:
  - Accept at edge E0 → `running`=1 after E0.
  - `clk_out` rises after edge E0+div, with `tick`=1 for exactly that cycle.
  - Thereafter `clk_out` toggles every div edges.
- Div change takes effect after the falling boundary. The next low phase already uses the new div.
- Stop latency:
  - `clk_out` stays high or low as normal until the next falling boundary.
  - At that edge `running`→0 and `cfg_ready`→1.
  - `tick` never fires after the stop boundary.
- `cfg_err` rises the cycle after the rejected transfer edge and lasts 1 cycle.
- Counter wrap: `cnt` never exceeds `act_div`−1. A div of 2^CNT_WIDTH−1 must work without overflow.

## Test plan
- Reset, then `cfg_div`=3, `cfg_en`=1 accepted at E0 → `clk_out` rises after E3, falls after E6, period 6. `tick` is high 1 cycle every 6 cycles.
- Running at div=3; send div=5 during the high phase → the high phase completes at 3 cycles. Then low 5 / high 5. `cfg_ready`=0 from acceptance until the falling boundary.
- Running at div=4; send `cfg_en`=0 during the low phase → the low phase finishes, a full 4-cycle high phase runs, then `clk_out`=0. `running`=0 and `cfg_ready`=1 at that boundary, with no further `tick`.
- `cfg_div`=1, then `cfg_div`=0, while running at div=2 → `cfg_err` pulses 1 cycle each time. `clk_out` period stays 4 and the state stays RUN.
- Assert `reset_n`=0 mid-cycle while in PEND → `clk_out`, `running` and `tick` go to 0 immediately. `cfg_ready`=1. After release, an en=1 command with div=2 gives period 4.
- Hold `cfg_valid` with div=6 while in PEND (div 2→3 queued) → no transfer while `cfg_ready`=0. The div=3 command is applied at the falling boundary; div=6 is accepted on the first edge after it and applied at the following falling boundary.
